// File: rtl/lock_key_loader.sv
// Serially loads a locked-netlist key plus XOR-fold checksum, arms it only when the checksum matches.
// Latency: CHECK occupies one cycle after the last checksum bit; arm or fail takes effect on the edge leaving it.
// Backpressure: bit_ready_o high only while shifting key/checksum bits; bits without ready are ignored.
module lock_key_loader #(
    parameter int               KEY_W     = 64,
    parameter int               CHK_W     = 8,
    parameter int               MAX_FAIL  = 3,
    parameter logic [KEY_W-1:0] DECOY_KEY = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic             clear_i,
    output logic             bit_ready_o,
    output logic [KEY_W-1:0] keyinput_o,
    output logic             key_armed_o,
    output logic             busy_o,
    output logic             fail_o,
    output logic [1:0]       fail_cnt_o,
    output logic             lockout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_KEY,
        S_SHIFT_CHK,
        S_CHECK,
        S_ARMED,
        S_LOCKOUT
    } state_t;

    localparam int         NSLICE   = KEY_W / CHK_W;
    localparam logic [6:0] KEY_LAST = 7'(KEY_W - 1);
    localparam logic [6:0] TOT_LAST = 7'(KEY_W + CHK_W - 1);

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   stage_q;
    logic [CHK_W-1:0]   chk_q;
    logic [CHK_W-1:0]   chk_calc;
    logic [KEY_W-1:0]   key_q;
    logic [6:0]         cnt_q;
    logic [1:0]         fail_cnt_q;
    logic [1:0]         fail_inc;
    logic               fail_q;
    logic               accept;
    logic               chk_ok;

    always_comb begin
        chk_calc = '0;
        for (int s = 0; s < NSLICE; s++) begin
            chk_calc = chk_calc ^ stage_q[s*CHK_W +: CHK_W];
        end
    end

    assign chk_ok      = (chk_q == chk_calc);
    assign fail_inc    = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;
    assign bit_ready_o = (state_q == S_SHIFT_KEY) || (state_q == S_SHIFT_CHK);
    assign accept      = bit_valid_i && bit_ready_o;
    assign busy_o      = bit_ready_o || (state_q == S_CHECK);
    assign key_armed_o = (state_q == S_ARMED);
    assign lockout_o   = (state_q == S_LOCKOUT);
    // Staging never reaches the key bus; only the verified copy does, and only while armed.
    assign keyinput_o  = key_armed_o ? key_q : DECOY_KEY;
    assign fail_o      = fail_q;
    assign fail_cnt_o  = fail_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_SHIFT_KEY;
            end
            S_SHIFT_KEY: begin
                if (clear_i)                             state_d = S_IDLE;
                else if (accept && cnt_q == KEY_LAST)    state_d = S_SHIFT_CHK;
            end
            S_SHIFT_CHK: begin
                if (clear_i)                             state_d = S_IDLE;
                else if (accept && cnt_q == TOT_LAST)    state_d = S_CHECK;
            end
            S_CHECK: begin
                if (clear_i)                                     state_d = S_IDLE;
                else if (chk_ok)                                 state_d = S_ARMED;
                else if ({30'd0, fail_inc} == 32'(MAX_FAIL))     state_d = S_LOCKOUT;
                else                                             state_d = S_IDLE;
            end
            S_ARMED: begin
                if (clear_i) state_d = S_IDLE;
            end
            S_LOCKOUT: begin
                state_d = S_LOCKOUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q    <= '0;
            chk_q      <= '0;
            cnt_q      <= '0;
            key_q      <= '0;
            fail_cnt_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            fail_q <= 1'b0;
            // Any return to IDLE (abort, fail, disarm) discards whatever was staged.
            if (state_d == S_IDLE) begin
                stage_q <= '0;
                chk_q   <= '0;
                cnt_q   <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 7'd1;
                if (state_q == S_SHIFT_KEY) begin
                    stage_q <= {bit_i, stage_q[KEY_W-1:1]};
                end else begin
                    chk_q <= {bit_i, chk_q[CHK_W-1:1]};
                end
            end

            if (state_q == S_CHECK && !clear_i) begin
                if (chk_ok) begin
                    key_q <= stage_q;
                end else begin
                    fail_q     <= 1'b1;
                    fail_cnt_q <= fail_inc;
                end
            end

            if (state_q == S_ARMED && clear_i) begin
                key_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lock_key_loader.sv
// Randomized bench for lock_key_loader: a checksum/fail-count model predicts arm and fail events,
// a negedge monitor pops them as the DUT raises key_armed_o or fail_o.
module tb_lock_key_loader;

    localparam int          KEY_W    = 64;
    localparam int          CHK_W    = 8;
    localparam int          MAX_FAIL = 3;
    localparam logic [63:0] DECOY    = 64'h0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              bit_valid_i = 1'b0;
    logic              bit_i = 1'b0;
    logic              clear_i = 1'b0;
    logic              bit_ready_o;
    logic [KEY_W-1:0]  keyinput_o;
    logic              key_armed_o;
    logic              busy_o;
    logic              fail_o;
    logic [1:0]        fail_cnt_o;
    logic              lockout_o;

    lock_key_loader #(
        .KEY_W     (KEY_W),
        .CHK_W     (CHK_W),
        .MAX_FAIL  (MAX_FAIL),
        .DECOY_KEY (DECOY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .bit_valid_i (bit_valid_i),
        .bit_i       (bit_i),
        .clear_i     (clear_i),
        .bit_ready_o (bit_ready_o),
        .keyinput_o  (keyinput_o),
        .key_armed_o (key_armed_o),
        .busy_o      (busy_o),
        .fail_o      (fail_o),
        .fail_cnt_o  (fail_cnt_o),
        .lockout_o   (lockout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fail;
        logic [63:0] key;
        int          cnt;
        bit          lock;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_fail = 0;
    bit   model_lock = 1'b0;
    bit   prev_armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Checksum = XOR of the eight bytes of the key.
    function automatic logic [7:0] fold(input logic [63:0] k);
        int r;
        r = 0;
        for (int s = 0; s < KEY_W / CHK_W; s++) r = r ^ int'((k >> (8 * s)) & 64'hFF);
        return 8'(r);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (fail_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fail_pulse", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_is_fail", 64'd1, 64'(mon_e.is_fail));
                    check("fail_cnt_at_fail", 64'(fail_cnt_o), 64'(mon_e.cnt));
                    check("lockout_at_fail", 64'(lockout_o), 64'(mon_e.lock));
                end
            end
            if (key_armed_o && !prev_armed) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_arm", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_is_arm", 64'd0, 64'(mon_e.is_fail));
                    check("armed_key", keyinput_o, mon_e.key);
                    check("fail_cnt_at_arm", 64'(fail_cnt_o), 64'(mon_e.cnt));
                end
            end
            if (!key_armed_o) check("decoy_when_unarmed", keyinput_o, DECOY);
            prev_armed = key_armed_o;
        end else begin
            prev_armed = 1'b0;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_keyinput"}, keyinput_o, DECOY);
        check({tag, "_armed"}, 64'(key_armed_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_fail"}, 64'(fail_o), 64'd0);
        check({tag, "_fail_cnt"}, 64'(fail_cnt_o), 64'd0);
        check({tag, "_lockout"}, 64'(lockout_o), 64'd0);
        check({tag, "_ready"}, 64'(bit_ready_o), 64'd0);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        model_fail = 0;
        model_lock = 1'b0;
        exp_q.delete();
    endtask

    // gap_mode: 0 back-to-back, 1 valid toggling every cycle, 2 random gaps.
    task automatic do_load(input logic [63:0] key, input logic [7:0] chk, input int gap_mode,
                           input int abort_at, input bit disarm);
        logic [71:0] data;
        bit          processed;
        bit          good;
        bit          phase;
        exp_t        e;
        int          i;
        data      = {chk, key};
        processed = !model_lock;
        good      = (chk == fold(key));
        phase     = 1'b0;
        if (processed && abort_at < 0) begin
            if (good) begin
                e = '{1'b0, key, model_fail, 1'b0};
            end else begin
                model_fail = (model_fail == 3) ? 3 : model_fail + 1;
                model_lock = (model_fail == MAX_FAIL);
                e = '{1'b1, DECOY, model_fail, model_lock};
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        if (processed) begin
            check("ready_after_start", 64'(bit_ready_o), 64'd1);
        end else begin
            check("lockout_ready", 64'(bit_ready_o), 64'd0);
            check("lockout_flag", 64'(lockout_o), 64'd1);
        end
        i = 0;
        while (i < 72) begin
            if ((gap_mode == 1 && phase) || (gap_mode == 2 && $urandom_range(3) == 0)) begin
                bit_valid_i = 1'b0;
                bit_i       = 1'($urandom);
                clear_i     = 1'b0;
                phase       = 1'b0;
            end else begin
                bit_valid_i = 1'b1;
                bit_i       = data[i];
                clear_i     = (i == abort_at);
                phase       = 1'b1;
                i++;
            end
            @(negedge clk);
            if (clear_i) begin
                clear_i     = 1'b0;
                bit_valid_i = 1'b0;
                check("abort_not_busy", 64'(busy_o), 64'd0);
                check("abort_fail_cnt", 64'(fail_cnt_o), 64'(model_fail));
                repeat (2) @(negedge clk);
                return;
            end
        end
        bit_valid_i = 1'b0;
        if (processed) begin
            check("check_state_busy", 64'(busy_o), 64'd1);
            check("check_state_not_ready", 64'(bit_ready_o), 64'd0);
            repeat (3) @(negedge clk);
            check("event_seen", 64'(exp_q.size()), 64'd0);
            check("armed_after_load", 64'(key_armed_o), 64'(good));
            if (good && disarm) begin
                clear_i = 1'b1;
                @(negedge clk);
                clear_i = 1'b0;
                check("disarm_armed", 64'(key_armed_o), 64'd0);
                check("disarm_decoy", keyinput_o, DECOY);
            end
        end else begin
            repeat (3) @(negedge clk);
            check("ignored_lockout", 64'(lockout_o), 64'd1);
            check("ignored_armed", 64'(key_armed_o), 64'd0);
            check("ignored_fail_cnt", 64'(fail_cnt_o), 64'(model_fail));
        end
    endtask

    initial begin
        logic [63:0] k;
        logic [7:0]  c;
        int          ab;

        #3 check_reset_outputs("reset_init");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(64'h0123456789ABCDEF, 8'h00, 0, -1, 1'b1);
        do_load(64'h0123456789ABCDEF, 8'h00, 1, -1, 1'b1);
        do_load(64'h0123456789ABCDEF, 8'h01, 0, -1, 1'b1);
        check("bad_chk_fail_cnt", 64'(fail_cnt_o), 64'd1);
        do_load(64'h0123456789ABCDEF, 8'h00, 0, 40, 1'b1);
        do_load(64'h0123456789ABCDEF, 8'h00, 0, -1, 1'b1);

        // Reset while armed drops the key.
        do_load(64'hFEDCBA9876543210, fold(64'hFEDCBA9876543210), 0, -1, 1'b0);
        pulse_reset();

        repeat (3) do_load(64'h0123456789ABCDEF, 8'h01, 2, -1, 1'b1);
        check("lockout_reached", 64'(lockout_o), 64'd1);
        do_load(64'h0123456789ABCDEF, 8'h00, 0, -1, 1'b1);
        pulse_reset();
        do_load(64'h0123456789ABCDEF, 8'h00, 0, -1, 1'b1);

        // Reset mid-shift, then bits without start must be ignored.
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        bit_valid_i = 1'b1;
        repeat (20) begin
            bit_i = 1'($urandom);
            @(negedge clk);
        end
        pulse_reset();
        repeat (3) begin
            bit_i = 1'($urandom);
            @(negedge clk);
            check("no_start_ready", 64'(bit_ready_o), 64'd0);
            check("no_start_busy", 64'(busy_o), 64'd0);
        end
        bit_valid_i = 1'b0;

        for (int n = 0; n < 30; n++) begin
            k  = {$urandom, $urandom};
            c  = ($urandom_range(2) != 0) ? fold(k) : fold(k) ^ 8'($urandom_range(255, 1));
            ab = ($urandom_range(5) == 0) ? int'($urandom_range(71)) : -1;
            do_load(k, c, 2 * int'($urandom_range(1)), ab, 1'b1);
            if (model_lock) begin
                k = {$urandom, $urandom};
                do_load(k, fold(k), 0, -1, 1'b1);
                pulse_reset();
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
